// File: rtl/stats_pkg.sv
// Shared definitions for the statistics engine: default widths and the
// controller state encoding used by the top level.
package stats_pkg;

   localparam int DEF_DATA_W = 8;
   localparam int DEF_CNT_W  = 8;
   localparam int DEF_SUM_W  = DEF_DATA_W + DEF_CNT_W;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DIV  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/restoring_divider.sv
// Multi-cycle restoring divider: one quotient bit per clock, SUM_W iterations.
// The quotient register doubles as the dividend shift register, so dividend
// bits leave at the top while quotient bits enter at the bottom.
module restoring_divider
   import stats_pkg::*;
#(
   parameter int SUM_W = DEF_SUM_W,
   parameter int CNT_W = DEF_CNT_W,
   parameter int QUO_W = SUM_W
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             abort,
   input  logic             start,
   input  logic [SUM_W-1:0] dividend,
   input  logic [CNT_W-1:0] divisor,
   output logic             done,
   output logic [QUO_W-1:0] quotient
);

   localparam int ITER_W = $clog2(SUM_W + 1);

   logic [SUM_W-1:0]  quo_reg;
   logic [SUM_W-1:0]  quo_next;
   logic [CNT_W-1:0]  rem_reg;
   logic [CNT_W-1:0]  rem_next;
   logic [CNT_W-1:0]  div_reg;
   logic [ITER_W-1:0] iter_reg;
   logic              done_reg;
   logic [CNT_W:0]    rem_shift;
   logic [CNT_W:0]    rem_diff;
   logic              fits;

   // One restoring step: shift in the next dividend bit, trial-subtract the
   // divisor, keep the difference only when it did not borrow.
   always_comb begin
      rem_shift = {rem_reg, quo_reg[SUM_W-1]};
      rem_diff  = rem_shift - {1'b0, div_reg};
      fits      = ~rem_diff[CNT_W];
      rem_next  = fits ? rem_diff[CNT_W-1:0] : rem_shift[CNT_W-1:0];
      quo_next  = {quo_reg[SUM_W-2:0], fits};
   end

   // Iteration control: load on start, step while the counter is non-zero,
   // flag done on the last step; abort drops any division in flight.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         quo_reg  <= '0;
         rem_reg  <= '0;
         div_reg  <= '0;
         iter_reg <= '0;
         done_reg <= 1'b0;
      end else if (abort) begin
         quo_reg  <= '0;
         rem_reg  <= '0;
         div_reg  <= '0;
         iter_reg <= '0;
         done_reg <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         if (start) begin
            quo_reg  <= dividend;
            rem_reg  <= '0;
            div_reg  <= divisor;
            iter_reg <= ITER_W'(SUM_W);
         end else if (iter_reg != '0) begin
            quo_reg  <= quo_next;
            rem_reg  <= rem_next;
            iter_reg <= iter_reg - ITER_W'(1);
            done_reg <= (iter_reg == ITER_W'(1));
         end
      end
   end

   assign done     = done_reg;
   assign quotient = quo_reg[QUO_W-1:0];

endmodule

// File: rtl/stats_unit.sv
// Streaming max/min/count/sum tracker with an on-demand floor average.
// All outputs are registered except in_ready, which gates the sample
// handshake on controller state, a pending average request and saturation.
module stats_unit
   import stats_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int CNT_W  = DEF_CNT_W
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    clear,
   input  logic                    in_valid,
   input  logic [DATA_W-1:0]       in_data,
   output logic                    in_ready,
   input  logic                    avg_req,
   output logic                    busy,
   output logic                    avg_valid,
   output logic [DATA_W-1:0]       MAX_out,
   output logic [DATA_W-1:0]       MIN_out,
   output logic [CNT_W-1:0]        COUNT_out,
   output logic [DATA_W+CNT_W-1:0] SUM_out,
   output logic [DATA_W-1:0]       AVG_out
);

   localparam int SUM_W = DATA_W + CNT_W;

   state_t            state_reg;
   logic              busy_reg;
   logic              avg_valid_reg;
   logic [DATA_W-1:0] avg_reg;
   logic [DATA_W-1:0] max_reg;
   logic [DATA_W-1:0] min_reg;
   logic [CNT_W-1:0]  count_reg;
   logic [SUM_W-1:0]  sum_reg;

   logic              count_full;
   logic              accept;
   logic              div_start;
   logic              div_done;
   logic [DATA_W-1:0] div_quotient;
   logic [DATA_W-1:0] max_next;
   logic [DATA_W-1:0] min_next;

   // Handshake and divider launch decisions, all taken in IDLE only.
   always_comb begin
      count_full = (count_reg == {CNT_W{1'b1}});
      in_ready   = (state_reg == IDLE) && !avg_req && !count_full;
      accept     = in_valid && in_ready;
      div_start  = (state_reg == IDLE) && avg_req && (count_reg != '0);
   end

   // Next extrema: the first sample seeds both, later ones compare unsigned.
   always_comb begin
      max_next = max_reg;
      min_next = min_reg;
      if (count_reg == '0) begin
         max_next = in_data;
         min_next = in_data;
      end else begin
         if (in_data > max_reg) max_next = in_data;
         if (in_data < min_reg) min_next = in_data;
      end
   end

   // Statistics registers: update on an accepted sample, frozen otherwise.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         max_reg   <= '0;
         min_reg   <= '1;
         count_reg <= '0;
         sum_reg   <= '0;
      end else if (clear) begin
         max_reg   <= '0;
         min_reg   <= '1;
         count_reg <= '0;
         sum_reg   <= '0;
      end else if (accept) begin
         max_reg   <= max_next;
         min_reg   <= min_next;
         count_reg <= count_reg + CNT_W'(1);
         sum_reg   <= sum_reg + {{CNT_W{1'b0}}, in_data};
      end
   end

   // Average controller: IDLE -> DIV -> DONE -> IDLE, or IDLE -> DONE when
   // there is nothing to divide; busy and avg_valid are registered with state.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg     <= IDLE;
         busy_reg      <= 1'b0;
         avg_valid_reg <= 1'b0;
         avg_reg       <= '0;
      end else if (clear) begin
         state_reg     <= IDLE;
         busy_reg      <= 1'b0;
         avg_valid_reg <= 1'b0;
         avg_reg       <= '0;
      end else begin
         avg_valid_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (avg_req) begin
                  busy_reg <= 1'b1;
                  if (count_reg == '0) begin
                     avg_reg       <= '0;
                     avg_valid_reg <= 1'b1;
                     state_reg     <= DONE;
                  end else begin
                     state_reg <= DIV;
                  end
               end
            end
            DIV: begin
               if (div_done) begin
                  avg_reg       <= div_quotient;
                  avg_valid_reg <= 1'b1;
                  state_reg     <= DONE;
               end
            end
            DONE: begin
               busy_reg  <= 1'b0;
               state_reg <= IDLE;
            end
            default: begin
               busy_reg  <= 1'b0;
               state_reg <= IDLE;
            end
         endcase
      end
   end

   // The quotient never exceeds DATA_W bits since SUM <= COUNT * max sample,
   // so only the low bits are brought out of the divider.
   restoring_divider #(
      .SUM_W (SUM_W),
      .CNT_W (CNT_W),
      .QUO_W (DATA_W)
   ) u_divider (
      .clk      (clk),
      .reset_n  (reset_n),
      .abort    (clear),
      .start    (div_start),
      .dividend (sum_reg),
      .divisor  (count_reg),
      .done     (div_done),
      .quotient (div_quotient)
   );

   assign busy      = busy_reg;
   assign avg_valid = avg_valid_reg;
   assign AVG_out   = avg_reg;
   assign MAX_out   = max_reg;
   assign MIN_out   = min_reg;
   assign COUNT_out = count_reg;
   assign SUM_out   = sum_reg;

endmodule
